// File: rtl/chunked_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : chunked_add_sequencer
// Purpose  : Multi-cycle wide adder. Operands are accepted over a valid/ready
//            handshake, added LSB-first one CHUNK-bit slice per cycle with
//            the inter-slice carry held in a flop, and the sum, carry-out and
//            signed overflow are returned over a second valid/ready handshake.
// Options  : `define ADDSEQ_SUB_EN adds the in_sub port (A-B when set).
// Revision : 1.0 - initial release
// ============================================================================
module chunked_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADDSEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               w_sub;
  logic               w_ready;
  logic [CHUNK:0]     w_slice;
  logic [CHUNK-1:0]   w_s;
  logic               w_c;
  logic               w_c_msb_in;
  logic [WIDTH-1:0]   w_sum_shift;

`ifdef ADDSEQ_SUB_EN
  assign w_sub = in_sub;
`else
  assign w_sub = 1'b0;
`endif

  // One CHUNK-bit full-adder slice working on the low bits of the shifters
  assign w_slice    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_q};
  assign w_s        = w_slice[CHUNK-1:0];
  assign w_c        = w_slice[CHUNK];
  // Carry into the slice MSB recovered from the MSB sum bit: s = a ^ b ^ cin
  assign w_c_msb_in = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ w_s[CHUNK-1];

  // New slice result enters the sum shifter from the top
  generate
    if (CHUNK == WIDTH) begin : g_single_chunk
      assign w_sum_shift = w_s;
    end else begin : g_multi_chunk
      assign w_sum_shift = {w_s, sum_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    w_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        w_ready = 1'b1;
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = w_sum_shift;
        carry_d = w_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          cout_d  = w_c;
          ovf_d   = w_c ^ w_c_msb_in;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Retiring the result frees the slot for a same-edge accept
        w_ready = out_ready;
        if (out_ready && !in_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rst) begin
      w_ready = 1'b0;
    end

    if (in_valid && w_ready) begin
      a_d     = in_a;
      b_d     = w_sub ? ~in_b : in_b;
      carry_d = w_sub ? 1'b1 : in_cin;
      cnt_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      state_d = S_RUN;
    end
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign out_sum   = sum_q;
  // Flags are only meaningful alongside a valid result
  assign out_cout  = cout_q & out_valid;
  assign out_ovf   = ovf_q & out_valid;

endmodule
`default_nettype wire

// File: doc/chunked_add_sequencer.md
Name: chunked_add_sequencer

Overview:
- Multi-cycle wide adder.
- Accepts two WIDTH-bit operands over a valid/ready handshake and sequences them LSB-first through one CHUNK-bit full-adder slice, one chunk per cycle.
- Holds the inter-chunk carry in a flop and returns sum, carry-out and signed overflow over a second valid/ready handshake.
- Used where a full-width single-cycle adder would cost too much area or timing in the standard-cell datapath.

Parameters:
- WIDTH, 32, operand and sum width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam; number of RUN cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in to bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  A+B+cin modulo 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1.
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN state.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE; out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0.
  - Internal carry and chunk counter cleared.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after deassertion.
- State IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: capture in_a and in_b into shift registers, carry<=in_cin, cnt<=0, go to RUN.
  - Inputs are sampled only at the accept edge; later changes are ignored.
- State RUN:
  - in_ready=0, busy=1.
  - Each cycle: {c, s} = a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry.
  - s shifts into sum_sh from the top.
  - a_sh and b_sh shift right by CHUNK.
  - carry<=c, cnt<=cnt+1.
  - On the last chunk (cnt==NCHUNK-1), also record the carry into bit CHUNK-1 of that slice for out_ovf, then go to DONE.
- State DONE:
  - out_valid=1.
  - out_sum, out_cout and out_ovf are registered and held stable until the output handshake.
  - in_ready=out_ready. If out_ready&&in_valid on the same edge, the result is retired and the new operands are accepted; next state is RUN.
  - If out_ready&&!in_valid, go to IDLE.
  - If !out_ready, hold all outputs.
- Latency:
  - out_valid rises NCHUNK cycles after the accept edge (WIDTH=32, CHUNK=8 gives 4).
  - Back-to-back issue interval is NCHUNK+1 cycles.
- Boundary cases:
  - CHUNK==WIDTH gives a single RUN cycle.
  - A carry ripples correctly across all chunk boundaries, e.g. all-ones + cin.
  - Sum wraps modulo 2^WIDTH; the carry is reported only on out_cout.
- Reset mid-RUN or mid-DONE aborts the operation with no partial result emitted. The next accepted operation is computed correctly.
- out_ovf and out_cout are cleared whenever out_valid is 0.

Optional Feature:
- Macro: ADDSEQ_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), sampled at the accept edge.
  - When in_sub=1: B is inverted at capture, initial carry=1, and in_cin is ignored. The result is A-B; out_cout=1 means no borrow.
  - When in_sub=0: behaviour is identical to the undefined case.
- Undefined: no in_sub port; add only.

Test Plan:
- A=0x000000FF, B=0x00000001, cin=0 -> out_sum=0x00000100, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- A=0xFFFFFFFF, B=0x00000000, cin=1 -> out_sum=0x00000000, cout=1, ovf=0 (carry through all 4 chunks).
- A=0x7FFFFFFF, B=0x00000001, cin=0 -> out_sum=0x80000000, cout=0, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stable, in_ready=0. Then out_ready=1 with in_valid=1 and A=3, B=4 -> both handshakes on the same edge, next result 0x00000007 after 4 cycles.
- Assert rst during RUN cycle 2 -> out_valid=0 and busy=0 immediately. Release, then A=0x12345678, B=0x11111111 -> 0x23456789, cout=0.
- (ADDSEQ_SUB_EN) A=5, B=7, in_sub=1 -> out_sum=0xFFFFFFFE, cout=0. A=7, B=5, in_sub=1 -> 0x00000002, cout=1.
